// File: rtl/bomb_pkg.sv
// Shared types, constants and helpers for the bomb scheduler and its two slots.
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [9:0] org;
        logic [9:0] span;
    } axis_span_t;

    localparam int TILE_SHIFT = 5;
    localparam int PLAYER_W   = 18;
    localparam int PLAYER_H   = 26;

    localparam logic [4:0] PAUSE_STOP = 5'b00000;
    localparam logic [4:0] PAUSE_HOLD = 5'b00001;
    localparam logic [4:0] PAUSE_OVER = 5'b11111;

    function automatic logic is_pause_code(input logic [4:0] code);
        return (code == PAUSE_STOP) || (code == PAUSE_HOLD) || (code == PAUSE_OVER);
    endfunction

    // Centre of the player sprite rounded down to the tile grid; the carry bit is dropped.
    function automatic logic [9:0] snap_tile(input logic [9:0] pos, input logic [9:0] half);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, half};
        sum = (sum >> TILE_SHIFT) << TILE_SHIFT;
        return sum[9:0];
    endfunction

    function automatic axis_span_t blast_axis(input logic [9:0] tile, input logic [2:0] radius,
                                              input logic [9:0] fmin, input logic [9:0] fmax);
        logic signed [10:0] lo;
        logic [11:0]        hi;
        logic [11:0]        lim;
        logic [11:0]        org_w;
        axis_span_t         r;
        lo = $signed({1'b0, tile}) - $signed({3'b000, radius, 5'b00000});
        if (lo < $signed({1'b0, fmin})) begin
            r.org = fmin;
        end else begin
            r.org = lo[9:0];
        end
        hi    = {2'b00, tile} + {3'b000, ({1'b0, radius} + 4'd1), 5'b00000};
        lim   = {2'b00, fmax} + 12'd1;
        hi    = (hi > lim) ? lim : hi;
        org_w = {2'b00, r.org};
        if (hi > org_w) begin
            r.span = 10'(hi - org_w);
        end else begin
            r.span = 10'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: fuse/blast sequencer, frame counter and clamped hazard rectangle.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter logic [9:0] FUSE_FRAMES  = 10'd120,
    parameter logic [9:0] BLAST_FRAMES = 10'd30,
    parameter logic [2:0] BLAST_RADIUS = 3'd2,
    parameter logic [9:0] FIELD_MIN    = 10'd32,
    parameter logic [9:0] FIELD_MAX_X  = 10'd575,
    parameter logic [9:0] FIELD_MAX_Y  = 10'd447
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        hold,
    input  logic        start,
    input  logic        chain,
    input  logic [9:0]  new_tile_x,
    input  logic [9:0]  new_tile_y,
    output slot_state_t state,
    output logic [9:0]  tile_x,
    output logic [9:0]  tile_y,
    output logic [9:0]  haz_x,
    output logic [9:0]  haz_y,
    output logic [9:0]  haz_xs,
    output logic [9:0]  haz_ys,
    output logic        blast_entry
);

    slot_state_t state_r, state_nxt_s;
    logic [9:0]  cnt_r, cnt_nxt_s;
    logic [9:0]  tile_x_r, tile_y_r, tile_x_nxt_s, tile_y_nxt_s;
    logic [9:0]  haz_x_r, haz_y_r, haz_xs_r, haz_ys_r;
    logic [9:0]  haz_x_nxt_s, haz_y_nxt_s, haz_xs_nxt_s, haz_ys_nxt_s;
    logic        blast_entry_s;
    axis_span_t  span_x_s, span_y_s;

    // Slot state, frame counter and captured tile.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            cnt_r    <= 10'd0;
            tile_x_r <= 10'd0;
            tile_y_r <= 10'd0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            tile_x_r <= tile_x_nxt_s;
            tile_y_r <= tile_y_nxt_s;
        end
    end

    // Next state: counters only move on unpaused frames; a chain hit cuts the fuse short.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        tile_x_nxt_s  = tile_x_r;
        tile_y_nxt_s  = tile_y_r;
        blast_entry_s = 1'b0;
        if (hold) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nxt_s  = FUSE;
                        cnt_nxt_s    = FUSE_FRAMES - 10'd1;
                        tile_x_nxt_s = new_tile_x;
                        tile_y_nxt_s = new_tile_y;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FUSE: begin
                    if ((cnt_r == 10'd0) || chain) begin
                        state_nxt_s   = BLAST;
                        cnt_nxt_s     = BLAST_FRAMES - 10'd1;
                        blast_entry_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - 10'd1;
                    end
                end
                BLAST: begin
                    if (cnt_r == 10'd0) begin
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - 10'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 10'd0;
                end
            endcase
        end
    end

    // Rectangle for the upcoming state: clamped blast box, or a zero-size marker at the tile.
    always_comb begin
        span_x_s = blast_axis(tile_x_nxt_s, BLAST_RADIUS, FIELD_MIN, FIELD_MAX_X);
        span_y_s = blast_axis(tile_y_nxt_s, BLAST_RADIUS, FIELD_MIN, FIELD_MAX_Y);
        if (state_nxt_s == BLAST) begin
            haz_x_nxt_s  = span_x_s.org;
            haz_y_nxt_s  = span_y_s.org;
            haz_xs_nxt_s = span_x_s.span;
            haz_ys_nxt_s = span_y_s.span;
        end else begin
            haz_x_nxt_s  = tile_x_nxt_s;
            haz_y_nxt_s  = tile_y_nxt_s;
            haz_xs_nxt_s = 10'd0;
            haz_ys_nxt_s = 10'd0;
        end
    end

    // Registered hazard rectangle.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            haz_x_r  <= 10'd0;
            haz_y_r  <= 10'd0;
            haz_xs_r <= 10'd0;
            haz_ys_r <= 10'd0;
        end else begin
            haz_x_r  <= haz_x_nxt_s;
            haz_y_r  <= haz_y_nxt_s;
            haz_xs_r <= haz_xs_nxt_s;
            haz_ys_r <= haz_ys_nxt_s;
        end
    end

    assign state       = state_r;
    assign tile_x      = tile_x_r;
    assign tile_y      = tile_y_r;
    assign haz_x       = haz_x_r;
    assign haz_y       = haz_y_r;
    assign haz_xs      = haz_xs_r;
    assign haz_ys      = haz_ys_r;
    assign blast_entry = blast_entry_s;

endmodule

// File: rtl/bomb_scheduler.sv
// Two-player bomb scheduler: drop edge detection, tile snap, same-tile arbitration, two slots.
// Define CHAIN_REACTION_EN to let a live blast set off a fusing bomb inside it.
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter logic [9:0] FUSE_FRAMES  = 10'd120,
    parameter logic [9:0] BLAST_FRAMES = 10'd30,
    parameter logic [2:0] BLAST_RADIUS = 3'd2,
    parameter logic [9:0] FIELD_MIN    = 10'd32,
    parameter logic [9:0] FIELD_MAX_X  = 10'd575,
    parameter logic [9:0] FIELD_MAX_Y  = 10'd447
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [4:0] allow,
    input  logic       drop1,
    input  logic       drop2,
    input  logic [9:0] user1X,
    input  logic [9:0] user1Y,
    input  logic [9:0] user2X,
    input  logic [9:0] user2Y,
    output logic [9:0] bomb1X,
    output logic [9:0] bomb1Y,
    output logic [9:0] bomb1XS,
    output logic [9:0] bomb1YS,
    output logic [9:0] bomb2X,
    output logic [9:0] bomb2Y,
    output logic [9:0] bomb2XS,
    output logic [9:0] bomb2YS,
    output logic [9:0] bomb_tile1X,
    output logic [9:0] bomb_tile1Y,
    output logic [9:0] bomb_tile2X,
    output logic [9:0] bomb_tile2Y,
    output logic [1:0] state1,
    output logic [1:0] state2,
    output logic       detonate
);

    localparam logic [9:0] HALF_W = 10'(PLAYER_W / 2);
    localparam logic [9:0] HALF_H = 10'(PLAYER_H / 2);

    logic        prev_drop1_r, prev_drop2_r, rr_r, rr_nxt_s, detonate_r;
    logic        paused_s, edge1_s, edge2_s, want1_s, want2_s, tie_s;
    logic        start1_s, start2_s, chain1_s, chain2_s, entry1_s, entry2_s;
    logic [9:0]  snap1x_s, snap1y_s, snap2x_s, snap2y_s;
    slot_state_t st1_s, st2_s;

    // Drop history follows the keys even while paused, so a key held through a pause never fires.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_drop1_r <= 1'b0;
            prev_drop2_r <= 1'b0;
        end else begin
            prev_drop1_r <= drop1;
            prev_drop2_r <= drop2;
        end
    end

    // Accept edges into idle slots; a same-tile tie goes to the pointer's player.
    always_comb begin
        paused_s = is_pause_code(allow);
        snap1x_s = snap_tile(user1X, HALF_W);
        snap1y_s = snap_tile(user1Y, HALF_H);
        snap2x_s = snap_tile(user2X, HALF_W);
        snap2y_s = snap_tile(user2Y, HALF_H);
        edge1_s  = drop1 & ~prev_drop1_r & ~paused_s;
        edge2_s  = drop2 & ~prev_drop2_r & ~paused_s;
        want1_s  = edge1_s && (st1_s == IDLE) &&
                   !((st2_s != IDLE) && (snap1x_s == bomb_tile2X) && (snap1y_s == bomb_tile2Y));
        want2_s  = edge2_s && (st2_s == IDLE) &&
                   !((st1_s != IDLE) && (snap2x_s == bomb_tile1X) && (snap2y_s == bomb_tile1Y));
        tie_s    = want1_s && want2_s && (snap1x_s == snap2x_s) && (snap1y_s == snap2y_s);
        start1_s = want1_s;
        start2_s = want2_s;
        rr_nxt_s = rr_r;
        if (tie_s) begin
            start1_s = ~rr_r;
            start2_s = rr_r;
            rr_nxt_s = ~rr_r;
        end else begin
            rr_nxt_s = rr_r;
        end
    end

    // Round-robin pointer: 0 favours player 1.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            rr_r <= 1'b0;
        end else begin
            rr_r <= rr_nxt_s;
        end
    end

`ifdef CHAIN_REACTION_EN
    assign chain1_s = (st1_s == FUSE) && (st2_s == BLAST) &&
                      (bomb_tile1X >= bomb2X) && ({1'b0, bomb_tile1X} < ({1'b0, bomb2X} + {1'b0, bomb2XS})) &&
                      (bomb_tile1Y >= bomb2Y) && ({1'b0, bomb_tile1Y} < ({1'b0, bomb2Y} + {1'b0, bomb2YS}));
    assign chain2_s = (st2_s == FUSE) && (st1_s == BLAST) &&
                      (bomb_tile2X >= bomb1X) && ({1'b0, bomb_tile2X} < ({1'b0, bomb1X} + {1'b0, bomb1XS})) &&
                      (bomb_tile2Y >= bomb1Y) && ({1'b0, bomb_tile2Y} < ({1'b0, bomb1Y} + {1'b0, bomb1YS}));
`else
    assign chain1_s = 1'b0;
    assign chain2_s = 1'b0;
`endif

    bomb_slot #(
        .FUSE_FRAMES(FUSE_FRAMES), .BLAST_FRAMES(BLAST_FRAMES), .BLAST_RADIUS(BLAST_RADIUS),
        .FIELD_MIN(FIELD_MIN), .FIELD_MAX_X(FIELD_MAX_X), .FIELD_MAX_Y(FIELD_MAX_Y)
    ) u_slot1 (
        .frame_clk(frame_clk), .Reset(Reset), .hold(paused_s), .start(start1_s), .chain(chain1_s),
        .new_tile_x(snap1x_s), .new_tile_y(snap1y_s), .state(st1_s),
        .tile_x(bomb_tile1X), .tile_y(bomb_tile1Y),
        .haz_x(bomb1X), .haz_y(bomb1Y), .haz_xs(bomb1XS), .haz_ys(bomb1YS),
        .blast_entry(entry1_s)
    );

    bomb_slot #(
        .FUSE_FRAMES(FUSE_FRAMES), .BLAST_FRAMES(BLAST_FRAMES), .BLAST_RADIUS(BLAST_RADIUS),
        .FIELD_MIN(FIELD_MIN), .FIELD_MAX_X(FIELD_MAX_X), .FIELD_MAX_Y(FIELD_MAX_Y)
    ) u_slot2 (
        .frame_clk(frame_clk), .Reset(Reset), .hold(paused_s), .start(start2_s), .chain(chain2_s),
        .new_tile_x(snap2x_s), .new_tile_y(snap2y_s), .state(st2_s),
        .tile_x(bomb_tile2X), .tile_y(bomb_tile2Y),
        .haz_x(bomb2X), .haz_y(bomb2Y), .haz_xs(bomb2XS), .haz_ys(bomb2YS),
        .blast_entry(entry2_s)
    );

    // One detonate pulse per frame however many slots enter blast together.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            detonate_r <= 1'b0;
        end else begin
            detonate_r <= entry1_s | entry2_s;
        end
    end

    assign state1   = st1_s;
    assign state2   = st2_s;
    assign detonate = detonate_r;

endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
Owns both players' bomb slots: detects drop requests, snaps bombs to the 32-px tile grid, arbitrates same-tile conflicts, then runs each bomb through fuse and blast phases.
Drives the hazard rectangles that each player module's bomb-collision inputs consume (bomb1* goes to player 2, bomb2* goes to player 1).
Runs once per frame on the frame clock.

Parameters:
FUSE_FRAMES, 10'd120, frames from placement to detonation (legal range 1..1023)
BLAST_FRAMES, 10'd30, frames the blast rectangle stays live (legal range 1..1023)
BLAST_RADIUS, 3'd2, blast half-extent in tiles
FIELD_MIN, 10'd32, play-field lower bound, X and Y
FIELD_MAX_X, 10'd575, play-field right bound
FIELD_MAX_Y, 10'd447, play-field bottom bound

Ports:
frame_clk  in  1  frame clock; the only clock
Reset  in  1  synchronous, active-high reset
allow  in  5  game-state code; 5'b00000, 5'b00001 and 5'b11111 mean paused
drop1, drop2  in  1  player bomb_drop levels
user1X, user1Y, user2X, user2Y  in  10  player top-left positions
bomb1X, bomb1Y, bomb1XS, bomb1YS  out  10  player-1 bomb hazard rectangle
bomb2X, bomb2Y, bomb2XS, bomb2YS  out  10  player-2 bomb hazard rectangle
bomb_tile1X, bomb_tile1Y, bomb_tile2X, bomb_tile2Y  out  10  bomb tile origins, for the sprite renderer
state1, state2  out  2  slot state: IDLE=0, FUSE=1, BLAST=2
detonate  out  1  one-frame pulse when any slot enters BLAST (sound/FX)

Behaviour:
- Clock and reset: one clock, frame_clk. Reset is synchronous and active-high.
- Reset values: all outputs 0, both slots IDLE, drop-edge registers 0, round-robin pointer = player 1.
- Reset mid-FUSE or mid-BLAST: both slots return to IDLE on that edge; no detonate pulse.
- Drop request: accepted only on a rising edge (dropN high, prev_dropN low).
  - A held key never re-triggers.
  - An edge while the player's own slot is not IDLE is discarded, not queued.
- Tile snap: tileX = ((userX+9) >> 5) << 5 and tileY = ((userY+13) >> 5) << 5 (player is 18x26).
  - Compute in 11 bits; truncate to 10 bits.
- Conflict rules:
  - A drop whose tile equals the other slot's non-IDLE tile is rejected.
  - Both edges in the same frame with equal tiles and both slots IDLE: the round-robin pointer's player wins.
  - The pointer then toggles to the other player. The loser's edge is discarded.
- Latency: edge sampled at frame k gives state=FUSE and valid tile outputs at the k+1 edge.
- Slot FSM:
  - IDLE -> FUSE on accepted drop. Counter loads FUSE_FRAMES-1.
  - FUSE: counter decrements each unpaused frame. At count 0 -> BLAST, counter loads BLAST_FRAMES-1, detonate=1 for that frame.
  - BLAST: decrements each unpaused frame. At 0 -> IDLE.
- Hazard rectangle outputs:
  - IDLE and FUSE: XS = YS = 0 (no hit possible); X and Y hold the tile origin.
  - BLAST: X = max(tileX - R*32, FIELD_MIN), XS = min(tileX + (R+1)*32, FIELD_MAX_X+1) - X. Y and YS are computed the same way against FIELD_MAX_Y. R = BLAST_RADIUS.
  - Subtraction is done signed 11-bit before clamping, so there is no underflow wrap.
- Pause (allow in the pause set):
  - Counters, states and the round-robin pointer freeze.
  - Drop edges are ignored, but prev_drop still tracks the input.
  - Outputs hold.
- Both slots reaching count 0 in the same frame: both enter BLAST; one detonate pulse.

Optional Feature:
CHAIN_REACTION_EN:
- Defined: a slot in FUSE whose tile origin lies inside the other slot's live BLAST rectangle (X <= tile < X+XS on both axes) enters BLAST on the next edge.
  - Its counter loads BLAST_FRAMES-1 and detonate pulses.
  - If it is also at count 0 that frame, it enters BLAST once only.
- Undefined: slots time out independently; the containment comparators are not built.

Decomposition:
- Package bomb_pkg:
  - slot_state_t enum (IDLE, FUSE, BLAST)
  - TILE_SHIFT=5, PLAYER_W=18, PLAYER_H=26
  - pause-code constants
  - function snap_tile
- Sub-module bomb_slot: one slot FSM, counter and clamped rectangle generator, instantiated twice.
- The top level holds edge detection, arbitration, the round-robin pointer and optional chain logic.

Test Plan:
- Reset, then drop1 rises with user1=(39,35) -> next frame state1=FUSE, tile1=(32,32), bomb1XS=0. After 120 frames state1=BLAST with detonate high for one frame; rectangle X=32, XS=96, Y=32, YS=96 (left/top clamp).
- Hold drop1 high for 500 frames -> exactly one bomb cycle: FUSE 120 frames, BLAST 30 frames, then IDLE with no re-fire.
- Both drops rise the same frame with both players at (300,200) -> player 1 gets FUSE, player 2 stays IDLE. Repeat after IDLE -> player 2 wins.
- Pause with allow=5'b00001 for 50 frames mid-FUSE -> BLAST entered at frame 170 after drop. Drop edges during pause are ignored.
- Assert Reset at frame 60 of FUSE -> both slots IDLE, all outputs 0, no detonate.
- CHAIN_REACTION_EN: bomb1 at tile (96,96), bomb2 at tile (160,96) placed 40 frames later -> bomb2 enters BLAST the edge after bomb1 detonates. Without the macro, bomb2 blasts 40 frames later.
